universal_shift_reg: RTL and testbench

//  - N-bit universal shift register built directly downstream of the codebase's negative-edge D flip-flop.
//  - It consumes the flip-flop's q/qbar pair as its storage and adds mode-selected next-state logic per bit.
//  - Modes: hold, shift right, shift left, parallel load.
//  - Feeds serial/parallel data to counters, serializers and display stages in the sequential_ckts tree.

---
 rtl/universal_shift_reg_pkg.sv | 9 +
 rtl/usr_cell.sv | 40 ++++
 rtl/universal_shift_reg.sv | 63 ++++++
 tb/tb_universal_shift_reg.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/universal_shift_reg_pkg.sv
// rtl/universal_shift_reg_pkg.sv - mode encodings and default width for the universal shift register
package universal_shift_reg_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam int USR_DEFAULT_N = 4;
endpackage

// File: rtl/usr_cell.sv
// rtl/usr_cell.sv - one register bit: 4:1 mode mux into a falling-edge DFF with synchronous active-low clear
module usr_cell
    import universal_shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] mode,
    input  logic       d_hold,
    input  logic       d_shr,
    input  logic       d_shl,
    input  logic       d_load,
    output logic       q,
    output logic       qbar
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = d_hold;
        case (mode)
            MODE_HOLD: q_d = d_hold;
            MODE_SHR:  q_d = d_shr;
            MODE_SHL:  q_d = d_shl;
            MODE_LOAD: q_d = d_load;
            default:   q_d = d_hold;
        endcase
    end

    // Falling edge matches the codebase DFF this register is built on.
    always_ff @(negedge clk) begin
        if (!clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - N-bit universal shift register (hold/shr/shl/load); USR_RING_EN adds ring rotation
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int N = USR_DEFAULT_N
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [1:0]   mode,
    input  logic         sin_r,
    input  logic         sin_l,
`ifdef USR_RING_EN
    input  logic         ring,
`endif
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic [N-1:0] qbar,
    output logic         sout_r,
    output logic         sout_l
);
    logic shr_in;
    logic shl_in;

`ifdef USR_RING_EN
    assign shr_in = ring ? q[0]   : sin_r;
    assign shl_in = ring ? q[N-1] : sin_l;
`else
    assign shr_in = sin_r;
    assign shl_in = sin_l;
`endif

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic from_left;
        logic from_right;

        // Shift right pulls from the higher neighbour; shift left from the lower one.
        if (i == N-1) begin : g_top
            assign from_left = shr_in;
        end else begin : g_mid_r
            assign from_left = q[i+1];
        end
        if (i == 0) begin : g_bot
            assign from_right = shl_in;
        end else begin : g_mid_l
            assign from_right = q[i-1];
        end

        usr_cell u_cell (
            .clk    (clk),
            .clr    (clr),
            .mode   (mode),
            .d_hold (q[i]),
            .d_shr  (from_left),
            .d_shl  (from_right),
            .d_load (d[i]),
            .q      (q[i]),
            .qbar   (qbar[i])
        );
    end

    assign sout_r = q[0];
    assign sout_l = q[N-1];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed-vector bench for universal_shift_reg (N=4)
module tb_universal_shift_reg;
    logic       clk;
    logic       clr;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic       ring;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       sout_r;
    logic       sout_l;

    int total;
    int bad;

    universal_shift_reg #(.N(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .mode   (mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
`ifdef USR_RING_EN
        .ring   (ring),
`endif
        .d      (d),
        .q      (q),
        .qbar   (qbar),
        .sout_r (sout_r),
        .sout_l (sout_l)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fall_edge();
        @(negedge clk);
        #2;
    endtask

    task automatic chk_q(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, q}, {28'd0, exp});
        chk({tag, "_qbar"}, {28'd0, qbar}, {28'd0, ~exp});
        chk({tag, "_sout"}, {30'd0, sout_l, sout_r}, {30'd0, exp[3], exp[0]});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr   = 1'b1;
        mode  = 2'b00;
        sin_r = 1'b0;
        sin_l = 1'b0;
        ring  = 1'b0;
        d     = 4'b0000;
        #2;

        // 1. clear beats load
        clr = 1'b0; mode = 2'b11; d = 4'b1111;
        fall_edge();
        chk_q("clr_wins", 4'b0000);

        // 2. load, and rising edge alone leaves q
        clr = 1'b1; mode = 2'b11; d = 4'b1010;
        fall_edge();
        chk_q("load_1010", 4'b1010);
        d = 4'b0101;
        @(posedge clk);
        #1;
        chk_q("rise_noop", 4'b1010);
        #2;

        // 3. shift right with sin_r=1
        mode = 2'b01; sin_r = 1'b1;
        fall_edge();
        chk_q("shr1", 4'b1101);
        fall_edge();
        chk_q("shr2", 4'b1110);

        // 4. shift left then hold
        mode = 2'b10; sin_l = 1'b0; sin_r = 1'b0;
        fall_edge();
        chk_q("shl", 4'b1100);
        mode = 2'b00; sin_l = 1'b1; sin_r = 1'b1; d = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            fall_edge();
            chk_q($sformatf("hold%0d", i), 4'b1100);
        end

        // shift left with sin_l=1 fills from bit 0
        mode = 2'b10; sin_l = 1'b1;
        fall_edge();
        chk_q("shl_in1", 4'b1001);

        // 5. clear mid-shift, then first shift acts on zero
        mode = 2'b11; d = 4'b0110;
        fall_edge();
        chk_q("load_0110", 4'b0110);
        mode = 2'b01; sin_r = 1'b1;
        fall_edge();
        chk_q("shr_pre_clr", 4'b1011);
        clr = 1'b0;
        fall_edge();
        chk_q("mid_clr", 4'b0000);
        clr = 1'b1;
        fall_edge();
        chk_q("post_clr", 4'b1000);

        // continuous shift right with sin_r=0 flushes in N edges
        sin_r = 1'b0; mode = 2'b11; d = 4'b1111;
        fall_edge();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) fall_edge();
        chk_q("flush", 4'b0000);

`ifdef USR_RING_EN
        // 6. ring rotation ignores sin_r
        mode = 2'b11; d = 4'b1000;
        fall_edge();
        ring = 1'b1; mode = 2'b01;
        begin
            logic [3:0] exp_ring [4];
            exp_ring[0] = 4'b0100;
            exp_ring[1] = 4'b0010;
            exp_ring[2] = 4'b0001;
            exp_ring[3] = 4'b1000;
            for (int i = 0; i < 4; i++) begin
                sin_r = ~sin_r;
                fall_edge();
                chk_q($sformatf("ring%0d", i), exp_ring[i]);
            end
        end
        mode = 2'b10; sin_l = 1'b0;
        fall_edge();
        chk_q("ring_shl", 4'b0001);
        ring = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
